// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM loader: FSM state encoding and frame constants.
package imem_loader_pkg;

  localparam logic [7:0]  LOADER_MAGIC   = 8'hA5;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DATA_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAGIC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  // States in which a load is in progress and the CPU is held.
  function automatic logic is_busy(state_e s);
    return (s == ST_MAGIC) || (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_DATA)  || (s == ST_WRITE);
  endfunction

  // States that accept bytes from the receiver and run the idle timeout.
  function automatic logic is_rx_state(state_e s);
    return (s == ST_MAGIC) || (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four little-endian bytes into one word; word_o/full_o reflect the byte being taken now.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        byte_i,
  input  logic              take_i,
  output logic [DATA_W-1:0] word_o,
  output logic              full_o
);

  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] data_q, data_d;

  // New bytes enter at the top, so after four takes byte0 sits in bits [7:0].
  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    if (clr) begin
      lane_d = 2'd0;
      data_d = '0;
    end else if (take_i) begin
      lane_d = lane_q + 2'd1;
      data_d = {byte_i, data_q[DATA_W-1:BYTE_W]};
    end
  end

  assign word_o = {byte_i, data_q[DATA_W-1:BYTE_W]};
  assign full_o = take_i && !clr && (lane_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      data_q <= '0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction RAM from a framed byte stream (MAGIC, LEN_LO, LEN_HI, 4N data bytes)
// while holding the CPU; all outputs are registered from the next-state logic.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [7:0]  MAGIC       = LOADER_MAGIC,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rx_ready_q, rx_ready_d;
  logic                wr_en_q, wr_en_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                take, start_ok;
  logic [DATA_W-1:0]   pk_word;
  logic                pk_full;

  assign take     = rx_valid_i && rx_ready_q;
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

  imem_loader_word_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .byte_i (rx_data_i),
    .take_i (take && (state_q == ST_DATA)),
    .word_o (pk_word),
    .full_o (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    to_cnt_d   = '0;

    if (is_rx_state(state_q) && !take) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d    = ST_MAGIC;
          word_cnt_d = '0;
        end
      end
      ST_MAGIC: begin
        if (take) state_d = (rx_data_i == MAGIC) ? ST_LEN_LO : ST_ERR;
      end
      ST_LEN_LO: begin
        if (take) begin
          len_lo_d = rx_data_i;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (take) begin
          len_d = {rx_data_i, len_lo_q};
          if (len_d == '0)                   state_d = ST_DONE;
          else if (32'(len_d) > MAX_WORDS)   state_d = ST_ERR;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_full) begin
          wr_addr_d = word_cnt_q[ADDR_W-1:0];
          wr_data_d = pk_word;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        state_d    = (32'(word_cnt_q) + 32'd1 == 32'(len_q)) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle too long between bytes aborts the load.
    if (is_rx_state(state_q) && !take && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
      state_d = ST_ERR;
    end

    rx_ready_d = is_rx_state(state_d);
    wr_en_d    = (state_d == ST_WRITE);
    busy_d     = is_busy(state_d);
    hold_d     = is_busy(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      to_cnt_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      to_cnt_q   <= to_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign cpu_hold_o = hold_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, bad magic, empty frame, timeout, streaming, reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        wr_en_o;
  logic [13:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [14:0] word_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [13:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(14), .MAGIC(8'hA5), .TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  // Log every IMEM write, one entry per strobe cycle.
  always @(negedge clk) begin
    if (wr_en_o) begin
      wa_q.push_back(wr_addr_o);
      wd_q.push_back(wr_data_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int n = 0; n < 50 && !sent; n++) begin
      if (rx_ready_o) sent = 1;
      tick();
    end
    rx_valid_i = 1'b0;
    if (!sent) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    logic [7:0] s5 [15];
    int idx, low, cyc;

    rst_n = 1'b0; start_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
    tick(); tick();
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_hold",  32'(cpu_hold_o), 32'd0);
    chk("rst_ready", 32'(rx_ready_o), 32'd0);
    chk("rst_wr",    {wr_en_o, 3'b0, wr_addr_o, 14'b0}, 32'd0);
    chk("rst_data",  wr_data_o, 32'd0);
    chk("rst_flags", {done_o, err_o, word_cnt_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: two-word frame
    pulse_start();
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_hold", 32'(cpu_hold_o), 32'd1);
    chk("t1_ready", 32'(rx_ready_o), 32'd1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("t1_wr_en", 32'(wr_en_o), 32'd1);
    chk("t1_wr_rdy", 32'(rx_ready_o), 32'd0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    tick();
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_hold_off", 32'(cpu_hold_o), 32'd0);
    chk("t1_busy_off", 32'(busy_o), 32'd0);
    chk("t1_cnt", 32'(word_cnt_o), 32'd2);
    chk("t1_nwr", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("t1_a0", 32'(wa_q[0]), 32'd0);
      chk("t1_d0", wd_q[0], 32'h0000_0013);
      chk("t1_a1", 32'(wa_q[1]), 32'd1);
      chk("t1_d1", wd_q[1], 32'h0010_0093);
    end
    clear_log();

    // 2: bad magic
    pulse_start();
    chk("t2_done_clr", 32'(done_o), 32'd0);
    chk("t2_cnt_clr", 32'(word_cnt_o), 32'd0);
    send_byte(8'h5A);
    chk("t2_err", 32'(err_o), 32'd1);
    chk("t2_hold", 32'(cpu_hold_o), 32'd0);
    tick();
    chk("t2_ready", 32'(rx_ready_o), 32'd0);
    chk("t2_nwr", wa_q.size(), 32'd0);

    // 3: empty frame
    pulse_start();
    chk("t3_err_clr", 32'(err_o), 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_cnt", 32'(word_cnt_o), 32'd0);
    chk("t3_nwr", wa_q.size(), 32'd0);

    // 4: timeout after 3 of 4 data bytes
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    for (int i = 0; i < 99; i++) tick();
    chk("t4_err_99", 32'(err_o), 32'd0);
    chk("t4_busy_99", 32'(busy_o), 32'd1);
    tick();
    chk("t4_err_100", 32'(err_o), 32'd1);
    chk("t4_hold", 32'(cpu_hold_o), 32'd0);
    chk("t4_nwr", wa_q.size(), 32'd0);

    // 5: streaming with rx_valid_i held high, N=3
    s5 = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    pulse_start();
    idx = 0; low = 0; cyc = 0;
    rx_valid_i = 1'b1;
    while (idx < 15 && cyc < 100) begin
      rx_data_i = s5[idx];
      if (rx_ready_o) idx++;
      else if (idx > 0) low++;
      tick();
      cyc++;
    end
    rx_data_i = 8'hFF;
    chk("t5_cycles", 32'(cyc), 32'd17);
    chk("t5_low", 32'(low), 32'd2);
    tick(); tick();
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_extra_rdy", 32'(rx_ready_o), 32'd0);
    chk("t5_cnt", 32'(word_cnt_o), 32'd3);
    rx_valid_i = 1'b0;
    chk("t5_nwr", wa_q.size(), 32'd3);
    if (wa_q.size() == 3) begin
      chk("t5_a0", 32'(wa_q[0]), 32'd0);
      chk("t5_a1", 32'(wa_q[1]), 32'd1);
      chk("t5_a2", 32'(wa_q[2]), 32'd2);
      chk("t5_d0", wd_q[0], 32'h0403_0201);
      chk("t5_d1", wd_q[1], 32'h0807_0605);
      chk("t5_d2", wd_q[2], 32'h0C0B_0A09);
    end
    clear_log();

    // 6: async reset mid-load, then a clean reload
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold_o), 32'd0);
    chk("t6_rst_ready", 32'(rx_ready_o), 32'd0);
    chk("t6_rst_data", wr_data_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    tick();
    chk("t6_done", 32'(done_o), 32'd1);
    chk("t6_nwr", wa_q.size(), 32'd1);
    if (wa_q.size() == 1) begin
      chk("t6_a0", 32'(wa_q[0]), 32'd0);
      chk("t6_d0", wd_q[0], 32'hEFBE_ADDE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
